// File: rtl/apu_port_pkg.sv
// Shared definitions for the APU controller port models:
// button bit positions, default shift length and the pad FSM states.
package apu_port_pkg;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int SHIFT_LEN_DEF = 8;

  typedef enum logic {
    ST_LATCH = 1'b0,
    ST_SHIFT = 1'b1
  } pad_state_t;
endpackage

// File: rtl/port_sync_edge.sv
// N-stage synchronizer with a one-cycle rising-edge pulse.
// The extra flop after the last stage only serves edge detection.
module port_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic              prev;

  // synchronizer chain plus delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      prev <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = sr[STAGES-1] & ~prev;
endmodule

// File: rtl/joypad_port_responder.sv
// Standard pad model behind the APU controller port (4021-style PISO).
// OUT0 high loads the buttons; each completed read (n_IN0 rising) shifts
// one bit toward D0; after SHIFT_LEN reads D0 returns FILL_VALUE.
// Optional turbo on A/B is enabled with the macro JOYPAD_TURBO_EN.
import apu_port_pkg::*;

module joypad_port_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int SHIFT_LEN   = SHIFT_LEN_DEF,
  parameter int FILL_VALUE  = 1
`ifdef JOYPAD_TURBO_EN
  ,
  parameter int TURBO_HALF  = 4096
`endif
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 OUT0,
  input  logic                 n_IN0,
  input  logic [SHIFT_LEN-1:0] BTN,
`ifdef JOYPAD_TURBO_EN
  input  logic                 TURBO_A,
  input  logic                 TURBO_B,
`endif
  output logic                 D0,
  output logic                 D0_OE
);
  localparam int   CW   = $clog2(SHIFT_LEN + 1);
  localparam logic FILL = 1'(FILL_VALUE);

  logic strb_s, strb_rise;
  logic nrd_s, rd_end;

  port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_strb_sync (
    .clk (CLK),
    .rst (RES),
    .d   (OUT0),
    .q   (strb_s),
    .rise(strb_rise)
  );

  port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rd_sync (
    .clk (CLK),
    .rst (RES),
    .d   (n_IN0),
    .q   (nrd_s),
    .rise(rd_end)
  );

  assign D0_OE = ~nrd_s;

  logic [SHIFT_LEN-1:0] load;

`ifdef JOYPAD_TURBO_EN
  logic [12:0] turbo_cnt;
  logic        turbo_phase;

  // free-running turbo square wave, TURBO_HALF cycles per half-period
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == 13'(TURBO_HALF - 1)) begin
      turbo_cnt   <= '0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 13'd1;
    end
  end

  // turbo only affects what gets latched, never an in-flight shift
  always_comb begin
    load        = BTN;
    load[BTN_A] = BTN[BTN_A] | (TURBO_A & turbo_phase);
    load[BTN_B] = BTN[BTN_B] | (TURBO_B & turbo_phase);
  end
`else
  assign load = BTN;
`endif

  pad_state_t           state;
  logic [SHIFT_LEN-1:0] sreg, sreg_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 d0_nxt;

  // next shifter/count: strobe wins over a concurrent read end
  always_comb begin
    sreg_nxt = sreg;
    cnt_nxt  = cnt;
    if (strb_s) begin
      sreg_nxt = load;
      cnt_nxt  = '0;
    end else if (rd_end) begin
      sreg_nxt = {FILL, sreg[SHIFT_LEN-1:1]};
      if (cnt != CW'(SHIFT_LEN)) cnt_nxt = cnt + CW'(1);
    end
    d0_nxt = (cnt_nxt == CW'(SHIFT_LEN)) ? FILL : sreg_nxt[0];
  end

  // pad FSM with registered shifter, count and D0
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state <= ST_SHIFT;
      sreg  <= '0;
      cnt   <= '0;
      D0    <= 1'b0;
    end else begin
      case (state)
        ST_LATCH: if (!strb_s)   state <= ST_SHIFT;
        ST_SHIFT: if (strb_rise) state <= ST_LATCH;
        default:                 state <= ST_SHIFT;
      endcase
      sreg <= sreg_nxt;
      cnt  <= cnt_nxt;
      D0   <= d0_nxt;
    end
  end
endmodule

// File: tb/tb_joypad_port_responder.sv
// Self-checking bench for joypad_port_responder: transaction-level model
// (latched byte + read index) checked every cycle D0_OE is high.
module tb_joypad_port_responder;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       out0 = 1'b0;
  logic       n_in0 = 1'b1;
  logic [7:0] btn = 8'hFF;
  logic       d0, d0_oe;

  int n_cmp = 0;
  int n_bad = 0;

  // model: byte captured at the last strobe and number of completed reads
  logic [7:0] m_latched = 8'h00;
  int         m_idx = 0;
  logic [3:0] hist;

  always #5 clk = ~clk;

`ifdef JOYPAD_TURBO_EN
  joypad_port_responder #(.SYNC_STAGES(S), .SHIFT_LEN(8), .FILL_VALUE(1), .TURBO_HALF(8)) dut (
    .CLK(clk), .RES(res), .OUT0(out0), .n_IN0(n_in0), .BTN(btn),
    .TURBO_A(1'b0), .TURBO_B(1'b0), .D0(d0), .D0_OE(d0_oe));
`else
  joypad_port_responder #(.SYNC_STAGES(S), .SHIFT_LEN(8), .FILL_VALUE(1)) dut (
    .CLK(clk), .RES(res), .OUT0(out0), .n_IN0(n_in0), .BTN(btn),
    .D0(d0), .D0_OE(d0_oe));
`endif

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit();
    return (m_idx >= 8) ? 1'b1 : m_latched[m_idx];
  endfunction

  // n_IN0 as seen S clock edges ago (what the bus-enable must follow)
  always @(posedge clk or posedge res) begin
    if (res) hist <= '1;
    else     hist <= {hist[2:0], n_in0};
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (res) begin
      check("rst_d0", d0, 1'b0);
      check("rst_oe", d0_oe, 1'b0);
    end else if ($time > 20) begin
      check("oe", d0_oe, ~hist[S-1]);
      if (d0_oe && !hist[S-1]) check("d0", d0, exp_bit());
    end
  end

  task automatic strobe(input logic [7:0] b);
    @(posedge clk); #1;
    btn = b;
    out0 = 1'b1;
    m_latched = b;
    m_idx = 0;
    repeat (6) @(posedge clk);
    #1 out0 = 1'b0;
    repeat (S + 3) @(posedge clk);
  endtask

  task automatic rd(input int lo, input int gap, output logic b);
    @(posedge clk); #1 n_in0 = 1'b0;
    repeat (lo) @(posedge clk);
    #1 b = d0;
    n_in0 = 1'b1;
    repeat (gap) @(posedge clk);
    if (!out0 && m_idx < 8) m_idx++;
  endtask

  logic       b;
  logic [7:0] exp8;

  initial begin
    #1 res = 1'b1;
    repeat (10) @(posedge clk);
    #1 res = 1'b0;
    m_latched = 8'h00;
    m_idx = 0;
    repeat (4) @(posedge clk);
    #2 check("post_rst_d0", d0, 1'b0);
    check("post_rst_oe", d0_oe, 1'b0);

    // basic read of 8'b1000_0101
    strobe(8'b1000_0101);
    exp8 = 8'b1000_0101;
    for (int i = 0; i < 8; i++) begin
      rd(4, 6, b);
      check("basic", b, exp8[i]);
    end
    // overrun returns fill
    for (int i = 0; i < 3; i++) begin
      rd(4, 6, b);
      check("overrun", b, 1'b1);
    end

    // restrobe mid-sequence
    strobe(8'h02);
    rd(4, 6, b); check("restrb0", b, 1'b0);
    rd(4, 6, b); check("restrb1", b, 1'b1);
    rd(4, 6, b); check("restrb2", b, 1'b0);
    strobe(8'h02);
    rd(4, 6, b); check("restrb_again", b, 1'b0);

    // strobe priority: reads while OUT0 high never shift
    @(posedge clk); #1;
    btn = 8'h01;
    out0 = 1'b1;
    m_latched = 8'h01;
    m_idx = 0;
    repeat (S + 3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rd(4, 6, b);
      check("strb_prio", b, 1'b1);
    end
    #1 out0 = 1'b0;
    repeat (S + 3) @(posedge clk);
    rd(4, 6, b); check("after_prio_a", b, 1'b1);
    rd(4, 6, b); check("after_prio_b", b, 1'b0);

    // long low read counts once; button change has no effect
    strobe(8'h05);
    btn = 8'hFA;
    rd(20, 6, b); check("long_rd", b, 1'b1);
    rd(4, 6, b);  check("long_next", b, 1'b0);

    // reset mid-sequence, then reads without strobe give 0
    strobe(8'hFF);
    rd(4, 6, b);
    @(posedge clk); #1 res = 1'b1;
    m_latched = 8'h00;
    m_idx = 0;
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    repeat (3) @(posedge clk);
    rd(4, 6, b); check("rst_mid0", b, 1'b0);
    rd(4, 6, b); check("rst_mid1", b, 1'b0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0: strobe(8'($urandom));
        1: begin @(posedge clk); #1 btn = 8'($urandom); end
        2: begin
          @(posedge clk); #1;
          out0 = 1'b1;
          m_latched = btn;
          m_idx = 0;
          repeat (S + 3) @(posedge clk);
          rd($urandom_range(3, 6), $urandom_range(5, 8), b);
          #1 out0 = 1'b0;
          repeat (S + 3) @(posedge clk);
        end
        default: rd($urandom_range(3, 6), $urandom_range(5, 8), b);
      endcase
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
